// File: rtl/floating_point_sqrt_scheduler_pkg.sv
// Shared floating-point types plus the scheduler's state and port-index types.
package floating_point_sqrt_scheduler_pkg;

    // IEEE-754 single-precision bit pattern
    typedef logic [31:0] float32_t;

    // Guard/round/sticky bits reported by the square-root unit
    typedef logic [2:0] round_bits_t;

    // Index of one of the two request ports
    typedef logic port_idx_t;

    // Scheduler states; one square-root operation in flight at most
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } sched_state_e;

endpackage

// File: rtl/round_robin_arbiter_2.sv
// Two-requester round-robin arbiter: a one-bit pointer names the preferred
// port, and after every grant the pointer moves to the port that lost.
module round_robin_arbiter_2
    import floating_point_sqrt_scheduler_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output port_idx_t  grant_idx_o
);

    port_idx_t prio_q;

    // Preferred port wins a tie; a lone requester always wins
    always_comb begin
        grant_o     = 2'b00;
        grant_idx_o = prio_q;
        if (req_i[prio_q]) begin
            grant_idx_o     = prio_q;
            grant_o[prio_q] = 1'b1;
        end else if (req_i[~prio_q]) begin
            grant_idx_o      = ~prio_q;
            grant_o[~prio_q] = 1'b1;
        end
    end

    // Pointer moves to the non-granted port once a grant is consumed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (advance_i) begin
            prio_q <= ~grant_idx_o;
        end
    end

endmodule

// File: rtl/floating_point_sqrt_scheduler.sv
// Shares one external square-root unit between two request ports. A request
// is latched, issued for one cycle, its result captured and held until
// writeback takes it. Flush abandons the operation; a result already issued
// to the unit is drained and discarded so it cannot be misattributed.
module floating_point_sqrt_scheduler
    import floating_point_sqrt_scheduler_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clk_en_i,
    input  logic                      flush_i,
    input  logic [1:0]                req_valid_i,
    output logic [1:0]                req_ready_o,
    input  float32_t [1:0]            req_operand_i,
    input  logic [1:0][TAG_WIDTH-1:0] req_tag_i,
    output logic                      sqrt_valid_o,
    output float32_t                  sqrt_operand_o,
    input  logic                      sqrt_valid_i,
    input  float32_t                  sqrt_result_i,
    input  logic                      sqrt_invalid_i,
    input  logic                      sqrt_inexact_i,
    input  round_bits_t               sqrt_round_bits_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output float32_t                  res_result_o,
    output logic                      res_invalid_o,
    output logic                      res_inexact_o,
    output round_bits_t               res_round_bits_o,
    output logic [TAG_WIDTH-1:0]      res_tag_o,
    output port_idx_t                 res_port_o,
    output logic                      busy_o
);

    sched_state_e         state_q;
    float32_t             operand_q;
    logic [TAG_WIDTH-1:0] tag_q;
    port_idx_t            port_q;
    logic                 res_valid_q;
    float32_t             res_result_q;
    logic                 res_invalid_q;
    logic                 res_inexact_q;
    round_bits_t          res_round_bits_q;

    logic [1:0] grant;
    port_idx_t  grant_idx;
    logic       grant_en;
    logic       accept;

    round_robin_arbiter_2 u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_valid_i),
        .advance_i   (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Grants are offered only while idle, enabled and not being flushed
    assign grant_en    = (state_q == S_IDLE) && clk_en_i && !flush_i;
    assign req_ready_o = grant & {2{grant_en}};
    assign accept      = |(req_ready_o & req_valid_i);

    assign sqrt_valid_o     = (state_q == S_ISSUE) && clk_en_i;
    assign sqrt_operand_o   = operand_q;
    assign res_valid_o      = res_valid_q;
    assign res_result_o     = res_result_q;
    assign res_invalid_o    = res_invalid_q;
    assign res_inexact_o    = res_inexact_q;
    assign res_round_bits_o = res_round_bits_q;
    assign res_tag_o        = tag_q;
    assign res_port_o       = port_q;
    assign busy_o           = (state_q != S_IDLE);

    // Scheduler FSM with the request and result holding registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            operand_q        <= '0;
            tag_q            <= '0;
            port_q           <= 1'b0;
            res_valid_q      <= 1'b0;
            res_result_q     <= '0;
            res_invalid_q    <= 1'b0;
            res_inexact_q    <= 1'b0;
            res_round_bits_q <= '0;
        end else if (clk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        operand_q <= req_operand_i[grant_idx];
                        tag_q     <= req_tag_i[grant_idx];
                        port_q    <= grant_idx;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The issue strobe is out this cycle either way, so a
                    // flush must still wait for the unit to answer.
                    state_q <= flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush_i) begin
                        state_q <= sqrt_valid_i ? S_IDLE : S_DRAIN;
                    end else if (sqrt_valid_i) begin
                        res_result_q     <= sqrt_result_i;
                        res_invalid_q    <= sqrt_invalid_i;
                        res_inexact_q    <= sqrt_inexact_i;
                        res_round_bits_q <= sqrt_round_bits_i;
                        res_valid_q      <= 1'b1;
                        state_q          <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (flush_i || res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (sqrt_valid_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_sqrt_scheduler.sv
// Bench for the square-root scheduler: a stub unit with programmable latency,
// a vector table, hand-written flush/reset/enable sequences and a randomized
// run checked against a transaction-level model of the scheduler.
module tb_floating_point_sqrt_scheduler;
    import floating_point_sqrt_scheduler_pkg::*;

    localparam int TW = 6;

    typedef struct {
        logic        port;
        logic [31:0] op;
        logic [5:0]  tag;
        int          lat;
        int          hold;
        logic [31:0] exp_res;
        logic        exp_inv;
        logic        exp_inex;
        logic [2:0]  exp_rb;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst, clk_en, flush;
    logic [1:0]          req_valid, req_ready;
    float32_t [1:0]      req_operand;
    logic [1:0][TW-1:0]  req_tag;
    logic                sqrt_valid_out;
    float32_t            sqrt_operand_out;
    logic                sqrt_valid_in;
    float32_t            sqrt_result_in;
    logic                sqrt_invalid_in, sqrt_inexact_in;
    round_bits_t         sqrt_rb_in;
    logic                res_valid, res_ready;
    float32_t            res_result;
    logic                res_invalid, res_inexact;
    round_bits_t         res_rb;
    logic [TW-1:0]       res_tag;
    port_idx_t           res_port;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stub unit control
    int          stub_lat     = 4;
    int          stub_cnt     = 0;
    int          stub_returns = 0;
    logic [31:0] stub_op      = 32'h0;
    bit          stray_req    = 1'b0;

    vec_t vecs[5];
    int   exp_order[6] = '{0, 1, 0, 1, 0, 1};

    // scratch and model state
    logic [1:0]  acc, pv;
    logic        exp_p, m_ptr, m_port;
    logic [31:0] m_op, er;
    logic [5:0]  m_tag;
    logic        ei, ex;
    logic [2:0]  erb;
    int          m_lat, acc_cyc, grants, ret0;
    bit          outstanding, seen, accepted, exp_rv;

    always #5 clk = ~clk;

    floating_point_sqrt_scheduler #(.TAG_WIDTH(TW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .clk_en_i          (clk_en),
        .flush_i           (flush),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_operand_i     (req_operand),
        .req_tag_i         (req_tag),
        .sqrt_valid_o      (sqrt_valid_out),
        .sqrt_operand_o    (sqrt_operand_out),
        .sqrt_valid_i      (sqrt_valid_in),
        .sqrt_result_i     (sqrt_result_in),
        .sqrt_invalid_i    (sqrt_invalid_in),
        .sqrt_inexact_i    (sqrt_inexact_in),
        .sqrt_round_bits_i (sqrt_rb_in),
        .res_valid_o       (res_valid),
        .res_ready_i       (res_ready),
        .res_result_o      (res_result),
        .res_invalid_o     (res_invalid),
        .res_inexact_o     (res_inexact),
        .res_round_bits_o  (res_rb),
        .res_tag_o         (res_tag),
        .res_port_o        (res_port),
        .busy_o            (busy)
    );

    // Behaviour of the stub unit: {result, invalid, inexact, round bits}
    function automatic logic [37:0] stub_fn(input logic [31:0] op);
        if (op == 32'h40800000) return {32'h40000000, 1'b0, 1'b0, 3'b000};
        if (op == 32'hBF800000) return {32'h7FC00000, 1'b1, 1'b0, 3'b101};
        return {op ^ 32'h0F0F0F0F, op[31], op[0], op[6:4]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_res(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            settle();
            if (res_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            settle();
            if (!busy) break;
            step();
        end
        check(name, busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        stub_lat = v.lat;
        req_valid = 2'b00;
        req_valid[v.port] = 1'b1;
        req_operand[v.port] = v.op;
        req_tag[v.port] = v.tag;
        res_ready = 1'b0;
        settle();
        check("vec_ready", req_ready, 2'b01 << v.port);
        step();
        req_valid = 2'b00;
        settle();
        check("vec_issue_valid", sqrt_valid_out, 1'b1);
        check("vec_issue_operand", sqrt_operand_out, v.op);
        for (int k = 0; k < v.lat; k++) begin
            step();
            settle();
            if (k == 0) check("vec_issue_single", sqrt_valid_out, 1'b0);
            if (k == v.lat - 1) check("vec_no_early_res", res_valid, 1'b0);
        end
        step();
        settle();
        check("vec_res_valid", res_valid, 1'b1);
        check("vec_res_result", res_result, v.exp_res);
        check("vec_res_invalid", res_invalid, v.exp_inv);
        check("vec_res_inexact", res_inexact, v.exp_inex);
        check("vec_res_rb", res_rb, v.exp_rb);
        check("vec_res_tag", res_tag, v.tag);
        check("vec_res_port", res_port, v.port);
        for (int h = 0; h < v.hold; h++) begin
            step();
            req_valid = 2'b11;
            settle();
            check("hold_res_valid", res_valid, 1'b1);
            check("hold_res_stable", {res_result, res_tag, res_rb}, {v.exp_res, v.tag, v.exp_rb});
            check("hold_no_ready", req_ready, 2'b00);
            check("hold_busy", busy, 1'b1);
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        step();
        settle();
        check("vec_done_res_valid", res_valid, 1'b0);
        check("vec_done_idle", busy, 1'b0);
        res_ready = 1'b0;
    endtask

    // Stub square-root unit: answers stub_lat cycles after each issue strobe
    initial begin
        sqrt_valid_in   = 1'b0;
        sqrt_result_in  = '0;
        sqrt_invalid_in = 1'b0;
        sqrt_inexact_in = 1'b0;
        sqrt_rb_in      = '0;
        forever begin
            @(negedge clk);
            sqrt_valid_in = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    {sqrt_result_in, sqrt_invalid_in, sqrt_inexact_in, sqrt_rb_in} = stub_fn(stub_op);
                    sqrt_valid_in = 1'b1;
                    stub_returns++;
                end
            end
            if (stray_req) begin
                sqrt_result_in = 32'hDEADBEEF;
                sqrt_valid_in  = 1'b1;
                stray_req      = 1'b0;
            end
            if (sqrt_valid_out && clk_en) begin
                stub_op  = sqrt_operand_out;
                stub_cnt = stub_lat;
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h40800000, 6'h15, 25, 0, 32'h40000000, 1'b0, 1'b0, 3'b000};
        vecs[1] = '{1'b1, 32'hBF800000, 6'h2A, 3,  0, 32'h7FC00000, 1'b1, 1'b0, 3'b101};
        vecs[2] = '{1'b0, 32'h41100001, 6'h3F, 1,  5, 32'h4E1F0F0E, 1'b0, 1'b1, 3'b000};
        vecs[3] = '{1'b1, 32'h00000070, 6'h01, 7,  2, 32'h0F0F0F7F, 1'b0, 1'b0, 3'b111};
        vecs[4] = '{1'b0, 32'hC0000031, 6'h20, 4,  1, 32'hCF0F0F3E, 1'b1, 1'b1, 3'b011};

        rst = 1'b1; clk_en = 1'b1; flush = 1'b0;
        req_valid = 2'b00; req_operand = '0; req_tag = '0; res_ready = 1'b0;
        step(); step();
        settle();
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_sqrt_valid", sqrt_valid_out, 1'b0);
        check("rst_res_data", {res_result, res_invalid, res_inexact, res_rb, res_tag, res_port}, 0);
        rst = 1'b0;
        step();

        // both ports valid after reset: strict alternation starting at port 0
        stub_lat = 2; res_ready = 1'b1; req_valid = 2'b11;
        req_operand[0] = 32'h3F800000; req_operand[1] = 32'h40800000;
        grants = 0;
        for (int c = 0; c < 200 && grants < 6; c++) begin
            settle();
            acc = req_valid & req_ready;
            if (acc != 2'b00) begin
                check("rr_order", acc, 2'b01 << exp_order[grants]);
                grants++;
            end
            step();
        end
        check("rr_six_grants", grants, 6);
        req_valid = 2'b00;
        wait_idle("rr_drained", 50);
        res_ready = 1'b0;

        // vector table
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // stray unit result while idle
        stray_req = 1'b1;
        step(); step();
        settle();
        check("stray_idle_busy", busy, 1'b0);
        check("stray_idle_res", res_valid, 1'b0);

        // flush during WAIT, port1 raised at once and held
        stub_lat = 10;
        req_valid = 2'b01; req_operand[0] = 32'h3F800000; req_tag[0] = 6'h05;
        settle();
        check("fw_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step(); step();
        ret0 = stub_returns;
        flush = 1'b1;
        req_valid = 2'b10; req_operand[1] = 32'h12345678; req_tag[1] = 6'h09;
        settle();
        check("fw_no_ready_in_wait", req_ready, 2'b00);
        step();
        flush = 1'b0;
        accepted = 1'b0;
        for (int c = 0; c < 40 && !accepted; c++) begin
            settle();
            check("fw_no_res", res_valid, 1'b0);
            acc = req_valid & req_ready;
            if (acc != 2'b00) begin
                check("fw_accept_after_return", stub_returns > ret0, 1'b1);
                check("fw_accept_port1", acc, 2'b10);
                accepted = 1'b1;
            end
            step();
        end
        check("fw_accepted", accepted, 1'b1);
        req_valid = 2'b00;
        stub_lat = 3;
        wait_res(40, seen);
        check("fw_res_seen", seen, 1'b1);
        check("fw_res_result", res_result, 32'h1D3B5977);
        check("fw_res_port", res_port, 1'b1);
        check("fw_res_tag", res_tag, 6'h09);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        wait_idle("fw_idle", 5);

        // reset during WAIT (with clock enable low), stray result later
        stub_lat = 14;
        req_valid = 2'b01; req_operand[0] = 32'h40800000; req_tag[0] = 6'h03;
        step();
        req_valid = 2'b00;
        step(); step();
        rst = 1'b1; clk_en = 1'b0;
        step();
        rst = 1'b0; clk_en = 1'b1;
        settle();
        check("rw_idle", busy, 1'b0);
        for (int c = 0; c < 15; c++) begin
            settle();
            check("rw_no_res", res_valid, 1'b0);
            check("rw_stays_idle", busy, 1'b0);
            step();
        end
        run_vec(vecs[1]);

        // flush in IDLE blocks the grant
        flush = 1'b1; req_valid = 2'b01; req_operand[0] = 32'h3F800000; stub_lat = 2;
        settle();
        check("fi_no_ready", req_ready, 2'b00);
        step();
        settle();
        check("fi_idle", busy, 1'b0);
        flush = 1'b0;
        settle();
        check("fi_ready_after", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        // flush in HOLD drops the result
        wait_res(20, seen);
        check("fh_res_seen", seen, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        check("fh_res_dropped", res_valid, 1'b0);
        check("fh_idle", busy, 1'b0);

        // flush in ISSUE still drives the issue strobe, then drains
        stub_lat = 3;
        req_valid = 2'b01; req_operand[0] = 32'h3F800000;
        step();
        req_valid = 2'b00;
        flush = 1'b1;
        settle();
        check("fis_strobe", sqrt_valid_out, 1'b1);
        step();
        flush = 1'b0;
        settle();
        check("fis_draining", busy, 1'b1);
        for (int c = 0; c < 6; c++) begin
            settle();
            check("fis_no_res", res_valid, 1'b0);
            step();
        end
        wait_idle("fis_idle", 5);

        // flush coincident with the unit result in WAIT
        stub_lat = 3;
        req_valid = 2'b01; req_operand[0] = 32'h3F800000;
        step();
        req_valid = 2'b00;
        step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        check("fc_idle", busy, 1'b0);
        check("fc_no_res", res_valid, 1'b0);

        // clock enable low freezes everything
        stub_lat = 2;
        req_valid = 2'b01; req_operand[0] = 32'h3F800000; req_tag[0] = 6'h11;
        clk_en = 1'b0;
        settle();
        check("ce_no_ready", req_ready, 2'b00);
        step();
        settle();
        check("ce_idle_hold", busy, 1'b0);
        clk_en = 1'b1;
        settle();
        check("ce_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        clk_en = 1'b0;
        settle();
        check("ce_no_issue", sqrt_valid_out, 1'b0);
        step();
        settle();
        check("ce_issue_hold", busy, 1'b1);
        clk_en = 1'b1;
        settle();
        check("ce_issue_resumes", sqrt_valid_out, 1'b1);
        wait_res(20, seen);
        check("ce_res_seen", seen, 1'b1);
        clk_en = 1'b0; res_ready = 1'b1;
        step();
        settle();
        check("ce_res_holds", res_valid, 1'b1);
        clk_en = 1'b1;
        step();
        settle();
        check("ce_res_taken", res_valid, 1'b0);
        res_ready = 1'b0;

        // randomized traffic against the transaction model
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 1'b0; pv = 2'b00; outstanding = 1'b0; acc_cyc = -10; m_lat = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 3) == 0) begin
                    pv[p] = 1'b1;
                    req_operand[p] = $urandom;
                    req_tag[p] = 6'($urandom);
                end
            end
            req_valid = pv;
            res_ready = ($urandom_range(0, 3) != 0);
            if (!outstanding) stub_lat = $urandom_range(1, 6);
            settle();
            if (outstanding && c == acc_cyc + 1) begin
                check("rand_issue", sqrt_valid_out, 1'b1);
                check("rand_issue_operand", sqrt_operand_out, m_op);
            end else begin
                check("rand_no_issue", sqrt_valid_out, 1'b0);
            end
            acc = req_valid & req_ready;
            if (!outstanding && pv != 2'b00) begin
                exp_p = (pv == 2'b11) ? m_ptr : pv[1];
                check("rand_grant", acc, 2'b01 << exp_p);
                m_op = req_operand[exp_p];
                m_tag = req_tag[exp_p];
                m_port = exp_p;
                m_lat = stub_lat;
                acc_cyc = c;
                outstanding = 1'b1;
                m_ptr = ~exp_p;
                pv[exp_p] = 1'b0;
            end else begin
                check("rand_no_grant", acc, 2'b00);
            end
            exp_rv = outstanding && (c >= acc_cyc + 2 + m_lat);
            check("rand_res_valid", res_valid, exp_rv);
            if (exp_rv) begin
                {er, ei, ex, erb} = stub_fn(m_op);
                check("rand_res_result", res_result, er);
                check("rand_res_flags", {res_invalid, res_inexact, res_rb}, {ei, ex, erb});
                check("rand_res_tag", res_tag, m_tag);
                check("rand_res_port", res_port, m_port);
                if (res_ready) outstanding = 1'b0;
            end
            step();
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        wait_idle("rand_drained", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
